// File: rtl/mem_access_unit.sv
// Memory-stage access unit: steers store lanes, extracts/extends load lanes, flags misalignment,
// and stalls the pipeline from issue until the data-bus acknowledge has been consumed.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] exmem_op_c_i,
   input  logic [4:0]  exmem_reg_waddr_i,
   input  logic        exmem_reg_we_i,
   input  logic        exmem_mtype_i,
   input  logic        exmem_mem_rw_i,
   input  logic [1:0]  exmem_mem_width_i,
   input  logic [31:0] exmem_mem_wr_data_i,
   input  logic        exmem_mem_rdtype_i,
   input  logic [31:0] exmem_mem_addr_i,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [3:0]  dbus_be_o,
   output logic [31:0] dbus_wdata_o,
   input  logic        dbus_ack_i,
   input  logic [31:0] dbus_rdata_i,
   output logic [31:0] mem_reg_wdata_o,
   output logic [4:0]  mem_reg_waddr_o,
   output logic        mem_reg_we_o,
   output logic        mem_stall_req_o,
   output logic        mem_misalign_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic [1:0]  off;
   logic        aligned;
   logic        misalign;
   logic        issue;
   logic        is_load;
   logic [3:0]  be_calc;
   logic [31:0] wd_calc;
   logic [31:0] shifted;
   logic [31:0] load_ext;

   assign off = exmem_mem_addr_i[1:0];

   always_comb begin
      aligned  = 1'b1;
      be_calc  = 4'b1111;
      wd_calc  = exmem_mem_wr_data_i;
      load_ext = rdata_q;
      shifted  = rdata_q >> {off, 3'b000};
      case (exmem_mem_width_i)
         2'b00: begin
            aligned  = 1'b1;
            be_calc  = 4'b0001 << off;
            wd_calc  = {4{exmem_mem_wr_data_i[7:0]}};
            load_ext = exmem_mem_rdtype_i ? {24'd0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            aligned  = ~off[0];
            be_calc  = 4'b0011 << {off[1], 1'b0};
            wd_calc  = {2{exmem_mem_wr_data_i[15:0]}};
            load_ext = exmem_mem_rdtype_i ? {16'd0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
         end
         default: begin
            aligned  = (off == 2'b00);
            be_calc  = 4'b1111;
            wd_calc  = exmem_mem_wr_data_i;
            load_ext = rdata_q;
         end
      endcase
   end

   assign misalign = exmem_mtype_i & ~aligned;
   assign issue    = exmem_mtype_i & aligned & (state_q == IDLE);
   assign is_load  = exmem_mtype_i & ~exmem_mem_rw_i;

   // Bus fields are latched at issue and held untouched through REQ.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = REQ;
               req_d   = 1'b1;
               we_d    = exmem_mem_rw_i;
               addr_d  = {exmem_mem_addr_i[31:2], 2'b00};
               be_d    = be_calc;
               wdata_d = wd_calc;
            end
         end
         REQ: begin
            if (dbus_ack_i) begin
               state_d = RESP;
               req_d   = 1'b0;
               rdata_d = dbus_rdata_i;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign dbus_req_o   = req_q;
   assign dbus_we_o    = we_q;
   assign dbus_addr_o  = addr_q;
   assign dbus_be_o    = be_q;
   assign dbus_wdata_o = wdata_q;

   // A load may only write back once its data has landed in the buffer (RESP).
   assign mem_stall_req_o = issue | (state_q == REQ);
   assign mem_misalign_o  = misalign;
   assign mem_reg_wdata_o = is_load ? load_ext : exmem_op_c_i;
   assign mem_reg_waddr_o = exmem_reg_waddr_i;
   assign mem_reg_we_o    = exmem_reg_we_i & ~misalign & ~(is_load & (state_q != RESP));

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-built reset/back-to-back sequences,
// and randomized accesses checked against an arithmetic model of the access rules.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] exmem_op_c_i;
   logic [4:0]  exmem_reg_waddr_i;
   logic        exmem_reg_we_i;
   logic        exmem_mtype_i;
   logic        exmem_mem_rw_i;
   logic [1:0]  exmem_mem_width_i;
   logic [31:0] exmem_mem_wr_data_i;
   logic        exmem_mem_rdtype_i;
   logic [31:0] exmem_mem_addr_i;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_ack_i;
   logic [31:0] dbus_rdata_i;
   logic [31:0] mem_reg_wdata_o;
   logic [4:0]  mem_reg_waddr_o;
   logic        mem_reg_we_o;
   logic        mem_stall_req_o;
   logic        mem_misalign_o;

   mem_access_unit dut (
      .clk                 (clk),
      .rst                 (rst),
      .exmem_op_c_i        (exmem_op_c_i),
      .exmem_reg_waddr_i   (exmem_reg_waddr_i),
      .exmem_reg_we_i      (exmem_reg_we_i),
      .exmem_mtype_i       (exmem_mtype_i),
      .exmem_mem_rw_i      (exmem_mem_rw_i),
      .exmem_mem_width_i   (exmem_mem_width_i),
      .exmem_mem_wr_data_i (exmem_mem_wr_data_i),
      .exmem_mem_rdtype_i  (exmem_mem_rdtype_i),
      .exmem_mem_addr_i    (exmem_mem_addr_i),
      .dbus_req_o          (dbus_req_o),
      .dbus_we_o           (dbus_we_o),
      .dbus_addr_o         (dbus_addr_o),
      .dbus_be_o           (dbus_be_o),
      .dbus_wdata_o        (dbus_wdata_o),
      .dbus_ack_i          (dbus_ack_i),
      .dbus_rdata_i        (dbus_rdata_i),
      .mem_reg_wdata_o     (mem_reg_wdata_o),
      .mem_reg_waddr_o     (mem_reg_waddr_o),
      .mem_reg_we_o        (mem_reg_we_o),
      .mem_stall_req_o     (mem_stall_req_o),
      .mem_misalign_o      (mem_misalign_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mtype, rw, rdtype, we;
      logic [1:0]  width;
      logic [31:0] addr, wd, opc;
      logic [4:0]  waddr;
   } op_t;

   typedef struct {
      int          stalls;
      logic [31:0] wb;
      logic        wb_chk;
      logic        wb_we;
      logic        mis;
      logic [31:0] baddr;
      logic [3:0]  be;
      logic [31:0] bwd;
      logic        bchk;
   } exp_t;

   typedef struct {
      op_t         op;
      int          n;
      logic [31:0] rd;
      exp_t        e;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int req_rises = 0;
   logic req_prev = 1'b0;

   always @(negedge clk) begin
      if (dbus_req_o && !req_prev) req_rises = req_rises + 1;
      req_prev = dbus_req_o;
   end

   task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
      end
   endtask

   function automatic op_t mk_op(logic mt, logic rw, logic [1:0] w, logic rt, logic we,
                                 logic [31:0] a, logic [31:0] wd, logic [31:0] opc, logic [4:0] wa);
      op_t o;
      o.mtype = mt; o.rw = rw; o.width = w; o.rdtype = rt; o.we = we;
      o.addr = a; o.wd = wd; o.opc = opc; o.waddr = wa;
      return o;
   endfunction

   function automatic exp_t mk_exp(int st, logic [31:0] wb, logic wbc, logic wwe, logic mis,
                                   logic [31:0] ba, logic [3:0] be, logic [31:0] bwd, logic bc);
      exp_t e;
      e.stalls = st; e.wb = wb; e.wb_chk = wbc; e.wb_we = wwe; e.mis = mis;
      e.baddr = ba; e.be = be; e.bwd = bwd; e.bchk = bc;
      return e;
   endfunction

   // Reference: each access is a block of nb bytes at byte offset off within a word.
   function automatic exp_t model(op_t op, int n, logic [31:0] rd);
      exp_t   e;
      int     nb, off;
      bit     al, ld;
      longint v;
      nb  = (op.width == 2'd0) ? 1 : (op.width == 2'd1) ? 2 : 4;
      off = int'(op.addr[1:0]);
      al  = (off % nb) == 0;
      ld  = op.mtype && !op.rw;
      e.mis    = op.mtype && !al;
      e.stalls = (op.mtype && al) ? n + 1 : 0;
      e.baddr  = op.addr - 32'(off);
      e.be     = 4'(((1 << nb) - 1) << (off - off % nb));
      e.bwd    = (nb == 1) ? (op.wd & 32'hFF) * 32'h01010101 :
                 (nb == 2) ? (op.wd & 32'hFFFF) * 32'h00010001 : op.wd;
      e.bchk   = op.mtype && op.rw && al;
      v = longint'(rd);
      v = v >> (8 * off);
      if (nb == 1) begin
         v = v % 256;
         if (!op.rdtype && v >= 128) v = v - 256;
      end else if (nb == 2) begin
         v = v % 65536;
         if (!op.rdtype && v >= 32768) v = v - 65536;
      end
      e.wb     = ld ? 32'(v) : op.opc;
      e.wb_chk = !(ld && !al);
      e.wb_we  = op.we && !e.mis;
      return e;
   endfunction

   // Presents one instruction, answers the bus after n request cycles, and holds the
   // inputs until the unit drops its stall. Entered and left at posedge+1.
   task automatic run_op(input string tag, input op_t op, input int n, input logic [31:0] rd, input exp_t e);
      int stalls = 0, reqc = 0, bad_bus = 0, bad_we = 0;
      bit done = 0;
      exmem_mtype_i = op.mtype;        exmem_mem_rw_i = op.rw;
      exmem_mem_width_i = op.width;    exmem_mem_rdtype_i = op.rdtype;
      exmem_reg_we_i = op.we;          exmem_mem_addr_i = op.addr;
      exmem_mem_wr_data_i = op.wd;     exmem_op_c_i = op.opc;
      exmem_reg_waddr_i = op.waddr;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         if (dbus_req_o) begin
            reqc++;
            dbus_ack_i   = (reqc == n);
            dbus_rdata_i = (reqc == n) ? rd : $urandom;
            if (dbus_addr_o !== e.baddr || dbus_we_o !== op.rw) bad_bus++;
            if (e.bchk && (dbus_be_o !== e.be || dbus_wdata_o !== e.bwd)) bad_bus++;
         end else begin
            dbus_ack_i   = 1'b0;
            dbus_rdata_i = $urandom;
         end
         #1;
         if (mem_stall_req_o) begin
            stalls++;
            if (op.mtype && !op.rw && mem_reg_we_o) bad_we++;
            @(posedge clk); #1;
         end else begin
            done = 1;
            chk(tag, "misalign", 32'(mem_misalign_o), 32'(e.mis));
            chk(tag, "wb_we", 32'(mem_reg_we_o), 32'(e.wb_we));
            chk(tag, "wb_waddr", 32'(mem_reg_waddr_o), 32'(op.waddr));
            if (e.wb_chk) chk(tag, "wb_data", mem_reg_wdata_o, e.wb);
         end
      end
      if (!done) chk(tag, "stall_timeout", 32'(1), 32'(0));
      chk(tag, "stall_cycles", 32'(stalls), 32'(e.stalls));
      chk(tag, "req_cycles", 32'(reqc), 32'((e.stalls == 0) ? 0 : e.stalls - 1));
      if (e.stalls > 0) begin
         chk(tag, "bus_fields", 32'(bad_bus), 32'(0));
         chk(tag, "load_we_early", 32'(bad_we), 32'(0));
      end
      dbus_ack_i = 1'b0;
      @(posedge clk); #1;
   endtask

   vec_t vecs[14];

   initial begin
      op_t  op;
      exp_t e;
      int   n;
      logic [31:0] rd;

      vecs[0]  = '{mk_op(1,0,2'd0+2'd2,0,1,32'h100,0,32'h11,5'd5), 1, 32'hDEADBEEF,
                   mk_exp(2,32'hDEADBEEF,1,1,0,32'h100,4'hF,0,0)};
      vecs[1]  = '{mk_op(1,0,2'd0,0,1,32'h103,0,32'h11,5'd6), 1, 32'h80FF0000,
                   mk_exp(2,32'hFFFFFF80,1,1,0,32'h100,0,0,0)};
      vecs[2]  = '{mk_op(1,0,2'd0,1,1,32'h103,0,32'h11,5'd6), 1, 32'h80FF0000,
                   mk_exp(2,32'h00000080,1,1,0,32'h100,0,0,0)};
      vecs[3]  = '{mk_op(1,1,2'd1,0,0,32'h202,32'h1234ABCD,32'h55,5'd0), 2, 32'h0,
                   mk_exp(3,32'h55,1,0,0,32'h200,4'b1100,32'hABCDABCD,1)};
      vecs[4]  = '{mk_op(1,0,2'd2,0,1,32'h102,0,32'h11,5'd3), 1, 32'h0,
                   mk_exp(0,0,0,0,1,0,0,0,0)};
      vecs[5]  = '{mk_op(0,0,2'd2,0,1,32'h0,0,32'hCAFEF00D,5'd7), 1, 32'h0,
                   mk_exp(0,32'hCAFEF00D,1,1,0,0,0,0,0)};
      vecs[6]  = '{mk_op(1,0,2'd1,1,1,32'h106,0,32'h11,5'd8), 1, 32'h80017FFF,
                   mk_exp(2,32'h00008001,1,1,0,32'h104,0,0,0)};
      vecs[7]  = '{mk_op(1,0,2'd1,0,1,32'h106,0,32'h11,5'd8), 1, 32'h80017FFF,
                   mk_exp(2,32'hFFFF8001,1,1,0,32'h104,0,0,0)};
      vecs[8]  = '{mk_op(1,1,2'd0,0,1,32'h301,32'h000000A5,32'h77,5'd9), 1, 32'h0,
                   mk_exp(2,32'h77,1,1,0,32'h300,4'b0010,32'hA5A5A5A5,1)};
      vecs[9]  = '{mk_op(1,1,2'd3,0,0,32'h304,32'h11223344,32'h66,5'd10), 3, 32'h0,
                   mk_exp(4,32'h66,1,0,0,32'h304,4'b1111,32'h11223344,1)};
      vecs[10] = '{mk_op(1,0,2'd3,0,1,32'h305,0,32'h11,5'd11), 1, 32'h0,
                   mk_exp(0,0,0,0,1,0,0,0,0)};
      vecs[11] = '{mk_op(1,1,2'd1,0,1,32'h101,32'h1234,32'h99,5'd12), 1, 32'h0,
                   mk_exp(0,32'h99,1,0,1,0,0,0,0)};
      vecs[12] = '{mk_op(1,0,2'd0,0,1,32'h101,0,32'h11,5'd13), 1, 32'h00007F00,
                   mk_exp(2,32'h0000007F,1,1,0,32'h100,0,0,0)};
      vecs[13] = '{mk_op(1,1,2'd1,0,0,32'h200,32'hFFFF0001,32'h44,5'd14), 1, 32'h0,
                   mk_exp(2,32'h44,1,0,0,32'h200,4'b0011,32'h00010001,1)};

      // Reset: registered bus outputs cleared, stall still follows the inputs.
      rst = 1'b1;
      dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
      exmem_mtype_i = 1'b0; exmem_mem_rw_i = 1'b0; exmem_mem_width_i = 2'd0;
      exmem_mem_rdtype_i = 1'b0; exmem_reg_we_i = 1'b0; exmem_mem_addr_i = 32'h0;
      exmem_mem_wr_data_i = 32'h0; exmem_op_c_i = 32'h0; exmem_reg_waddr_i = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", "req", 32'(dbus_req_o), 0);
      chk("reset", "we", 32'(dbus_we_o), 0);
      chk("reset", "addr", dbus_addr_o, 0);
      chk("reset", "be", 32'(dbus_be_o), 0);
      chk("reset", "wdata", dbus_wdata_o, 0);
      chk("reset", "stall_idle", 32'(mem_stall_req_o), 0);
      exmem_mtype_i = 1'b1; exmem_mem_width_i = 2'd2; exmem_mem_addr_i = 32'h100;
      #1;
      chk("reset", "stall_memop", 32'(mem_stall_req_o), 1);
      exmem_mtype_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].n, vecs[i].rd, vecs[i].e);

      // Slow ack followed immediately by a second load: exactly two requests.
      req_rises = 0;
      op = mk_op(1,0,2'd2,0,1,32'h500,0,32'h1,5'd1);
      run_op("slow_ack", op, 5, 32'h01234567, mk_exp(6,32'h01234567,1,1,0,32'h500,4'hF,0,0));
      op = mk_op(1,0,2'd1,1,1,32'h502,0,32'h1,5'd2);
      run_op("b2b", op, 1, 32'hBEEF0000, mk_exp(2,32'h0000BEEF,1,1,0,32'h500,0,0,0));
      chk("b2b", "req_rises", 32'(req_rises), 2);

      // Reset while in REQ, then a stale ack in IDLE must not be captured.
      exmem_mtype_i = 1'b1; exmem_mem_rw_i = 1'b0; exmem_mem_width_i = 2'd2;
      exmem_mem_addr_i = 32'h400; exmem_reg_we_i = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_req", "req_before", 32'(dbus_req_o), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_in_req", "req_after", 32'(dbus_req_o), 0);
      exmem_mem_addr_i = 32'h102;
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'hFFFFFFFF;
      #1;
      chk("rst_in_req", "stall_late_ack", 32'(mem_stall_req_o), 0);
      @(posedge clk); #1;
      dbus_ack_i = 1'b0;
      chk("rst_in_req", "req_late_ack", 32'(dbus_req_o), 0);
      chk("rst_in_req", "buf_not_captured", mem_reg_wdata_o, 32'h0);
      op = mk_op(1,0,2'd0,0,1,32'h402,0,32'h1,5'd4);
      run_op("rst_recover", op, 1, 32'h00C30000, model(op, 1, 32'h00C30000));

      // Randomized accesses against the reference model.
      for (int k = 0; k < 150; k++) begin
         op.mtype  = ($urandom_range(3) != 0);
         op.rw     = 1'($urandom);
         op.width  = 2'($urandom);
         op.rdtype = 1'($urandom);
         op.we     = 1'($urandom);
         op.addr   = $urandom;
         op.wd     = $urandom;
         op.opc    = $urandom;
         op.waddr  = 5'($urandom);
         n  = $urandom_range(4, 1);
         rd = $urandom;
         e  = model(op, n, rd);
         run_op($sformatf("rand%0d", k), op, n, rd, e);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit, downstream of the EX/MEM pipeline register: consumes its memory-request fields (mtype, rw, width, write data, read type, address) and carries the access out on the data bus. Performs byte-lane steering for stores, lane extraction and sign/zero extension for loads, and misalignment detection. Requests a pipeline stall from the flow controller until the bus acknowledges, then hands the write-back value to the MEM/WB register.

## Interface
Parameters: none; all widths fixed at 32-bit data/address.

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- exmem_op_c_i  in  32  ALU result, write-back value for non-loads
- exmem_reg_waddr_i  in  5  destination register
- exmem_reg_we_i  in  1  register write enable
- exmem_mtype_i  in  1  1 = memory instruction
- exmem_mem_rw_i  in  1  0 = load, 1 = store
- exmem_mem_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- exmem_mem_wr_data_i  in  32  store data, low bits significant
- exmem_mem_rdtype_i  in  1  0 = sign-extend, 1 = zero-extend
- exmem_mem_addr_i  in  32  byte address
- dbus_req_o  out  1  bus request, registered
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  32  word address, {addr[31:2], 2'b00}
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_ack_i  in  1  one-cycle completion pulse
- dbus_rdata_i  in  32  read word, valid with ack
- mem_reg_wdata_o  out  32  write-back data
- mem_reg_waddr_o  out  5  passthrough of exmem_reg_waddr_i
- mem_reg_we_o  out  1  gated write enable
- mem_stall_req_o  out  1  to flow controller; holds EX/MEM and upstream
- mem_misalign_o  out  1  misaligned access flag

## Operation
- FSM: IDLE, REQ, RESP.
- IDLE: if mtype=1 and aligned -> latch bus fields, dbus_req_o<=1, go REQ. Otherwise stay.
- REQ: hold all bus outputs stable. On dbus_ack_i: dbus_req_o<=0, capture dbus_rdata_i into rdata buffer, go RESP.
- RESP: unconditionally -> IDLE. The instruction still on the inputs is not reissued.
- mem_stall_req_o (combinational) = (IDLE & mtype & aligned) | REQ. Low in RESP.
- Alignment: half needs addr[0]=0; word/11 needs addr[1:0]=00; byte always aligned.
- Misaligned (mtype=1): no request, no stall; mem_misalign_o=1 while presented; mem_reg_we_o=0.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Store data: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
- Load: shifted = rdata_buf >> (8*addr[1:0]); byte/half take low 8/16 bits, then extend per rdtype; word = rdata_buf.
- mem_reg_wdata_o = extended load data when mtype & !rw, else exmem_op_c_i.
- mem_reg_we_o = exmem_reg_we_i & !misalign & !(load & state!=RESP). A load writes back only in its RESP cycle.
- Stores complete in RESP with mem_reg_we_o per exmem_reg_we_i (normally 0).

## Timing
- Reset: state IDLE; dbus_req_o=0, dbus_we_o=0, dbus_addr_o=0, dbus_be_o=0, dbus_wdata_o=0, rdata buffer=0. Combinational outputs follow inputs (stall=1 if an aligned mem op is present).
- Reset in REQ aborts tracking; a late ack arriving in IDLE is ignored.
- Minimum access: IDLE cycle (stall) -> REQ with ack same cycle -> RESP. Two stall cycles; data on mem_reg_wdata_o in the RESP cycle.
- Ack latency N cycles after req rises -> N+1 stall cycles.
- Non-memory instructions: zero added latency.
- Back-to-back memory instructions: RESP -> IDLE -> new access. One IDLE stall cycle is the issue cycle.
- Inputs are required stable while stall is asserted (EX/MEM held by the flow controller). A flush during REQ does not cancel the bus transaction.

## Test plan
- Word load, addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF -> be=1111, addr 0x100, stall 2 cycles, RESP wdata 0xDEADBEEF, we=1.
- Byte load signed, addr 0x103, rdata 0x80FF_0000 -> be=1000 not driven (load reads word); wdata 0xFFFFFF80; same with rdtype=1 -> 0x00000080.
- Half store, addr 0x202, wd 0x1234ABCD -> dbus_we=1, be=1100, wdata 0xABCDABCD, addr 0x200.
- Word load at addr 0x102 -> mem_misalign_o=1, no dbus_req_o, stall 0, mem_reg_we_o=0.
- Ack delayed 5 cycles then back-to-back load -> req held stable 5 cycles, stall 6 cycles, second access issued after RESP->IDLE, exactly 2 requests total.
- Assert rst in REQ, then ack arrives -> req=0 after reset edge, state IDLE, ack ignored.
